// File: rtl/ixu_mc_unit.sv
// ixu_mc_unit: multi-cycle RV32M multiply/divide unit on the scheduler's ixu_mc issue port.
// Define IXU_MC_DIV_EN to build the divider; without it, div ops complete with cmpl_exc_o set.
module ixu_mc_unit (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic        core_flush_i,
  input  logic        ixu_mc_vld_i,
  input  logic [17:0] ixu_mc_data_i,
  input  logic [2:0]  ixu_mc_op_i,
  input  logic [5:0]  ixu_mc_prd_i,
  output logic        ixu_mc_busy_o,
  output logic [5:0]  rf_rs1_o,
  output logic [5:0]  rf_rs2_o,
  input  logic [31:0] rf_rs1_data_i,
  input  logic [31:0] rf_rs2_data_i,
  output logic        wb_vld_o,
  output logic [5:0]  wb_prd_o,
  output logic [31:0] wb_data_o,
  output logic        wk_vld_o,
  output logic [5:0]  wk_o,
  output logic        cmpl_vld_o,
  output logic [5:0]  cmpl_rob_o,
  output logic        cmpl_exc_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned PROD_W = 2 * XLEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MUL1,
    ST_MUL2,
`ifdef IXU_MC_DIV_EN
    ST_DIV,
    ST_FIX,
`endif
    ST_DONE
  } state_e;

  state_e                     state_q;
  logic [2:0]                 op_q;
  logic [TAG_W-1:0]           rs1_q;
  logic [TAG_W-1:0]           rs2_q;
  logic [TAG_W-1:0]           prd_q;
  logic [TAG_W-1:0]           rob_q;
  logic signed [XLEN:0]       a_q;
  logic signed [XLEN:0]       b_q;
  logic [PROD_W-1:0]          prod_q;
  logic [XLEN-1:0]            res_q;
  logic                       wb_en_q;
  logic                       exc_q;

  // Operand signedness: mul ops by MULH/MULHSU/MULHU encoding, div ops by the U bit
  logic a_sgn_d;
  logic b_sgn_d;
  assign a_sgn_d = op_q[2] ? !op_q[0] : !(op_q[1] & op_q[0]);
  assign b_sgn_d = op_q[2] ? !op_q[0] : !op_q[1];

  logic signed [PROD_W-1:0] a_ext_d;
  logic signed [PROD_W-1:0] b_ext_d;
  logic signed [PROD_W-1:0] prod_d;
  assign a_ext_d = PROD_W'(a_q);
  assign b_ext_d = PROD_W'(b_q);
  assign prod_d  = a_ext_d * b_ext_d;

`ifdef IXU_MC_DIV_EN
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [4:0]      cnt_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic [XLEN-1:0] rs1_mag_d;
  logic [XLEN-1:0] rs2_mag_d;
  logic            div_zero_d;
  logic            div_ovf_d;
  logic [XLEN:0]   rem_sh_d;
  logic [XLEN:0]   diff_d;
  logic [XLEN-1:0] quo_fix_d;
  logic [XLEN-1:0] rem_fix_d;

  assign rs1_mag_d  = (a_sgn_d && rf_rs1_data_i[XLEN-1]) ? -rf_rs1_data_i : rf_rs1_data_i;
  assign rs2_mag_d  = (b_sgn_d && rf_rs2_data_i[XLEN-1]) ? -rf_rs2_data_i : rf_rs2_data_i;
  assign div_zero_d = (rf_rs2_data_i == '0);
  assign div_ovf_d  = !op_q[0] && (rf_rs1_data_i == 32'h8000_0000) &&
                      (rf_rs2_data_i == 32'hFFFF_FFFF);

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  assign rem_sh_d  = {rem_q, quo_q[XLEN-1]};
  assign diff_d    = rem_sh_d - {1'b0, dvs_q};
  assign quo_fix_d = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix_d = neg_rem_q ? -rem_q : rem_q;
`endif

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      prd_q     <= '0;
      rob_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      res_q     <= '0;
      wb_en_q   <= 1'b0;
      exc_q     <= 1'b0;
`ifdef IXU_MC_DIV_EN
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else if (core_flush_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ixu_mc_vld_i) begin
            op_q    <= ixu_mc_op_i;
            rs2_q   <= ixu_mc_data_i[17:12];
            rs1_q   <= ixu_mc_data_i[11:6];
            rob_q   <= ixu_mc_data_i[5:0];
            prd_q   <= ixu_mc_prd_i;
            wb_en_q <= 1'b1;
            exc_q   <= 1'b0;
            state_q <= ST_RD;
          end
        end
        ST_RD: begin
          a_q <= {a_sgn_d & rf_rs1_data_i[XLEN-1], rf_rs1_data_i};
          b_q <= {b_sgn_d & rf_rs2_data_i[XLEN-1], rf_rs2_data_i};
          if (!op_q[2]) begin
            state_q <= ST_MUL1;
          end else begin
`ifdef IXU_MC_DIV_EN
            if (div_zero_d) begin
              res_q   <= op_q[1] ? rf_rs1_data_i : 32'hFFFF_FFFF;
              state_q <= ST_DONE;
            end else if (div_ovf_d) begin
              res_q   <= op_q[1] ? 32'h0000_0000 : 32'h8000_0000;
              state_q <= ST_DONE;
            end else begin
              quo_q     <= rs1_mag_d;
              dvs_q     <= rs2_mag_d;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= a_sgn_d & (rf_rs1_data_i[XLEN-1] ^ rf_rs2_data_i[XLEN-1]);
              neg_rem_q <= a_sgn_d & rf_rs1_data_i[XLEN-1];
              state_q   <= ST_DIV;
            end
`else
            // No divider: release dependents and raise illegal-instruction
            res_q   <= '0;
            wb_en_q <= 1'b0;
            exc_q   <= 1'b1;
            state_q <= ST_DONE;
`endif
          end
        end
        ST_MUL1: begin
          prod_q  <= prod_d;
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          res_q   <= (op_q[1:0] == 2'b00) ? prod_q[XLEN-1:0] : prod_q[PROD_W-1:XLEN];
          state_q <= ST_DONE;
        end
`ifdef IXU_MC_DIV_EN
        ST_DIV: begin
          quo_q <= {quo_q[XLEN-2:0], !diff_d[XLEN]};
          rem_q <= diff_d[XLEN] ? rem_sh_d[XLEN-1:0] : diff_d[XLEN-1:0];
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          res_q   <= op_q[1] ? rem_fix_d : quo_fix_d;
          state_q <= ST_DONE;
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Scheduler samples busy before selecting; an issue during DONE lands in IDLE
  assign ixu_mc_busy_o = ixu_mc_vld_i | ((state_q != ST_IDLE) && (state_q != ST_DONE));
  assign rf_rs1_o      = (state_q == ST_IDLE) ? ixu_mc_data_i[11:6]  : rs1_q;
  assign rf_rs2_o      = (state_q == ST_IDLE) ? ixu_mc_data_i[17:12] : rs2_q;

  logic done_c;
  assign done_c     = (state_q == ST_DONE) && !core_flush_i;
  assign wb_vld_o   = done_c & wb_en_q;
  assign wk_vld_o   = done_c;
  assign cmpl_vld_o = done_c;
  assign wb_data_o  = res_q;
  assign wb_prd_o   = prd_q;
  assign wk_o       = prd_q;
  assign cmpl_rob_o = rob_q;
  assign cmpl_exc_o = exc_q;

endmodule

// File: tb/tb_ixu_mc_unit.sv
// tb_ixu_mc_unit: directed bench for ixu_mc_unit; expectations follow IXU_MC_DIV_EN.
`timescale 1ns/1ps
module tb_ixu_mc_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        vld;
  logic [17:0] data;
  logic [2:0]  op;
  logic [5:0]  prd;
  logic        busy;
  logic [5:0]  rs1_tag;
  logic [5:0]  rs2_tag;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_vld;
  logic [5:0]  wb_prd;
  logic [31:0] wb_data;
  logic        wk_vld;
  logic [5:0]  wk;
  logic        cmpl_vld;
  logic [5:0]  cmpl_rob;
  logic        cmpl_exc;

  int errors = 0;
  int checks = 0;

  ixu_mc_unit dut (
    .core_clock_i  (clk),
    .core_reset_i  (rst),
    .core_flush_i  (flush),
    .ixu_mc_vld_i  (vld),
    .ixu_mc_data_i (data),
    .ixu_mc_op_i   (op),
    .ixu_mc_prd_i  (prd),
    .ixu_mc_busy_o (busy),
    .rf_rs1_o      (rs1_tag),
    .rf_rs2_o      (rs2_tag),
    .rf_rs1_data_i (rs1_data),
    .rf_rs2_data_i (rs2_data),
    .wb_vld_o      (wb_vld),
    .wb_prd_o      (wb_prd),
    .wb_data_o     (wb_data),
    .wk_vld_o      (wk_vld),
    .wk_o          (wk),
    .cmpl_vld_o    (cmpl_vld),
    .cmpl_rob_o    (cmpl_rob),
    .cmpl_exc_o    (cmpl_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle N: present packet; cycle N+1 (RD): supply operands, scramble issue bus
  task automatic issue(input logic [2:0] o, input logic [5:0] t1, input logic [5:0] t2,
                       input logic [5:0] p, input logic [5:0] r,
                       input logic [31:0] a, input logic [31:0] b);
    step();
    chk("pre_issue_busy", 32'(busy), 32'd0);
    chk("pre_issue_cmpl_vld", 32'(cmpl_vld), 32'd0);
    chk("pre_issue_wk_vld", 32'(wk_vld), 32'd0);
    vld  = 1'b1;
    data = {t2, t1, r};
    op   = o;
    prd  = p;
    #1;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_rs1_tag", 32'(rs1_tag), 32'(t1));
    chk("issue_rs2_tag", 32'(rs2_tag), 32'(t2));
    step();
    vld      = 1'b0;
    data     = ~{t2, t1, r};
    op       = ~o;
    prd      = ~p;
    rs1_data = a;
    rs2_data = b;
    #1;
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_rs1_tag", 32'(rs1_tag), 32'(t1));
    chk("rd_rs2_tag", 32'(rs2_tag), 32'(t2));
  endtask

  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] p, input logic [5:0] r, input int lat,
                        input logic [31:0] exp_data, input logic exp_wb, input logic exp_exc);
    issue(o, 6'(p + 6'd1), 6'(p + 6'd2), p, r, a, b);
    for (int c = 2; c <= lat; c++) begin
      step();
      rs1_data = ~a;
      rs2_data = ~b;
      if (c < lat) begin
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_early_cmpl"}, 32'(cmpl_vld), 32'd0);
      end
    end
    chk({name, "_done_busy"}, 32'(busy), 32'd0);
    chk({name, "_wb_vld"}, 32'(wb_vld), 32'(exp_wb));
    chk({name, "_wk_vld"}, 32'(wk_vld), 32'd1);
    chk({name, "_cmpl_vld"}, 32'(cmpl_vld), 32'd1);
    chk({name, "_cmpl_exc"}, 32'(cmpl_exc), 32'(exp_exc));
    chk({name, "_wb_prd"}, 32'(wb_prd), 32'(p));
    chk({name, "_wk"}, 32'(wk), 32'(p));
    chk({name, "_cmpl_rob"}, 32'(cmpl_rob), 32'(r));
    chk({name, "_wb_data"}, wb_data, exp_data);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    vld      = 1'b0;
    data     = '0;
    op       = '0;
    prd      = '0;
    rs1_data = '0;
    rs2_data = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wb_vld", 32'(wb_vld), 32'd0);
    chk("rst_wk_vld", 32'(wk_vld), 32'd0);
    chk("rst_cmpl_vld", 32'(cmpl_vld), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_prd", 32'(wb_prd), 32'd0);
    chk("rst_cmpl_rob", 32'(cmpl_rob), 32'd0);
    chk("rst_cmpl_exc", 32'(cmpl_exc), 32'd0);
    vld = 1'b1;
    #1;
    chk("rst_busy_follows_vld", 32'(busy), 32'd1);
    vld = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Multiply class, DONE four cycles after accept
    run_op("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 6'd12, 6'd5, 4, 32'hFFFF_FFEB, 1'b1, 1'b0);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd20, 6'd6, 4, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd21, 6'd7, 4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mulh_min2", OP_MULH, 32'h8000_0000, 32'h8000_0000, 6'd22, 6'd8, 4, 32'h4000_0000, 1'b1, 1'b0);
    run_op("mulh_m2x3", OP_MULH, 32'hFFFF_FFFE, 32'd3, 6'd23, 6'd9, 4, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0000, 6'd24, 6'd10, 4, 32'h0000_0000, 1'b1, 1'b0);
    run_op("mul_small", OP_MUL, 32'h0001_2345, 32'h10, 6'd25, 6'd11, 4, 32'h0012_3450, 1'b1, 1'b0);

`ifdef IXU_MC_DIV_EN
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd30, 6'd12, 35, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 6'd31, 6'd13, 35, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 6'd32, 6'd14, 35, 32'hFFFF_FFFD, 1'b1, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 6'd33, 6'd15, 35, 32'd1, 1'b1, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 6'd34, 6'd16, 35, 32'd14, 1'b1, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 6'd35, 6'd17, 35, 32'd2, 1'b1, 1'b0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 6'd36, 6'd18, 35, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd37, 6'd19, 35, 32'd0, 1'b1, 1'b0);
    run_op("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 6'd38, 6'd20, 35, 32'h8000_0000, 1'b1, 1'b0);
    run_op("remu_7_0", OP_REMU, 32'd7, 32'd0, 6'd39, 6'd21, 2, 32'd7, 1'b1, 1'b0);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 6'd40, 6'd22, 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 6'd41, 6'd23, 2, 32'hFFFF_FFFB, 1'b1, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd42, 6'd24, 2, 32'h8000_0000, 1'b1, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd43, 6'd25, 2, 32'd0, 1'b1, 1'b0);

    // Flush during divide iteration 10
    issue(OP_DIVU, 6'd1, 6'd2, 6'd44, 6'd26, 32'd100, 32'd7);
    for (int i = 0; i < 11; i++) step();
`else
    run_op("divu_nodiv", OP_DIVU, 32'd100, 32'd7, 6'd30, 6'd12, 2, 32'd0, 1'b0, 1'b1);
    run_op("rem_nodiv", OP_REM, 32'hFFFF_FFF9, 32'd2, 6'd31, 6'd13, 2, 32'd0, 1'b0, 1'b1);

    // Flush during MUL1
    issue(OP_MUL, 6'd1, 6'd2, 6'd44, 6'd26, 32'd3, 32'd5);
    step();
`endif
    flush = 1'b1;
    #1;
    chk("flush_mid_cmpl", 32'(cmpl_vld), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy_low", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("flush_no_strobe", 32'(wk_vld | cmpl_vld | wb_vld), 32'd0);
    end
    // exc must clear on a later multiply in either build
    run_op("mul_after_flush", OP_MUL, 32'd6, 32'd7, 6'd45, 6'd27, 4, 32'd42, 1'b1, 1'b0);

    // Flush coincident with issue: packet is dropped
    step();
    vld   = 1'b1;
    flush = 1'b1;
    data  = {6'd3, 6'd4, 6'd28};
    op    = OP_MUL;
    prd   = 6'd46;
    #1;
    chk("flush_issue_busy", 32'(busy), 32'd1);
    step();
    vld   = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_issue_dropped", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("flush_issue_no_strobe", 32'(cmpl_vld), 32'd0);
    end

    // Flush coincident with DONE suppresses the strobes
    issue(OP_MUL, 6'd5, 6'd6, 6'd47, 6'd29, 32'd2, 32'd2);
    step();
    step();
    step();
    chk("done_pre_flush_cmpl", 32'(cmpl_vld), 32'd1);
    flush = 1'b1;
    #1;
    chk("done_flush_wb_vld", 32'(wb_vld), 32'd0);
    chk("done_flush_wk_vld", 32'(wk_vld), 32'd0);
    chk("done_flush_cmpl_vld", 32'(cmpl_vld), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("done_flush_idle", 32'(busy), 32'd0);

    // Asynchronous reset during MUL1
    issue(OP_MUL, 6'd7, 6'd8, 6'd48, 6'd30, 32'd9, 32'd9);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_strobes", 32'(wb_vld | wk_vld | cmpl_vld), 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_cmpl_rob", 32'(cmpl_rob), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst_no_result", 32'(cmpl_vld), 32'd0);
    end
    run_op("mul_after_rst", OP_MUL, 32'hFFFF_FFFF, 32'd5, 6'd49, 6'd31, 4, 32'hFFFF_FFFB, 1'b1, 1'b0);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
